// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between N requesters, the wrr_arbiter and the downstream port.
// Requesters and downstream drive the master side; the arbiter takes the slave side.
interface wrr_arbiter_if #(
   parameter int N_OF_INPUTS = 4,
   parameter int WEIGHT_W    = 4
);
   localparam int IDX_W = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;

   // Handshake: req_i is a level per source. A beat of the granted source
   // transfers on every cycle where grant_o[owner] and ack_i are both high;
   // last_i only counts on such a cycle and marks the packet's final beat.
   logic [N_OF_INPUTS-1:0]          req_i;
   logic [N_OF_INPUTS*WEIGHT_W-1:0] weight_i;
   logic                            ack_i;
   logic                            last_i;
   logic [N_OF_INPUTS-1:0]          grant_o;
   logic [IDX_W-1:0]                grant_idx_o;
   logic                            busy_o;
   logic                            timeout_o;

   modport master (
      output req_i, weight_i, ack_i, last_i,
      input  grant_o, grant_idx_o, busy_o, timeout_o
   );

   modport slave (
      input  req_i, weight_i, ack_i, last_i,
      output grant_o, grant_idx_o, busy_o, timeout_o
   );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with packet locking; optional grant watchdog
// enabled by defining WRR_ARB_WATCHDOG_EN.
module wrr_arbiter #(
   parameter int N_OF_INPUTS    = 4,
   parameter int WEIGHT_W       = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic          clk,
   input  logic          arst,
   wrr_arbiter_if.slave  bus,
   output logic          dbg_state_o
);
   localparam int IDX_W = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [WEIGHT_W-1:0]  credit_q, credit_d;
   logic [N_OF_INPUTS-1:0] grant_q, grant_d;

   logic [IDX_W-1:0]     win_idx;
   logic                 win_found;
   logic [WEIGHT_W-1:0]  win_weight;
   logic [IDX_W-1:0]     next_ptr;
   logic                 do_release;

`ifdef WRR_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0]      wd_q, wd_d;
   logic                 timeout_q, timeout_d;
`else
   logic                 unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

   // First requester at or after ptr_q, wrapping modulo N.
   always_comb begin
      int cand;
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int k = 0; k < N_OF_INPUTS; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= N_OF_INPUTS) cand = cand - N_OF_INPUTS;
         if (!win_found && bus.req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   assign win_weight = bus.weight_i[int'(win_idx)*WEIGHT_W +: WEIGHT_W];
   assign next_ptr   = (int'(owner_q) == N_OF_INPUTS - 1) ? '0 : owner_q + IDX_W'(1);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      credit_d   = credit_q;
      grant_d    = grant_q;
      do_release = 1'b0;
`ifdef WRR_ARB_WATCHDOG_EN
      wd_d       = wd_q;
      timeout_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d          = LOCKED;
               owner_d          = win_idx;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               credit_d         = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
`ifdef WRR_ARB_WATCHDOG_EN
               wd_d             = '0;
`endif
            end
         end
         LOCKED: begin
            if (bus.ack_i && bus.last_i) begin
`ifdef WRR_ARB_WATCHDOG_EN
               wd_d = '0;
`endif
               // Keep the grant only if the owner has another packet ready.
               if (credit_q > WEIGHT_W'(1) && bus.req_i[owner_q]) begin
                  credit_d = credit_q - WEIGHT_W'(1);
               end else begin
                  do_release = 1'b1;
               end
            end
`ifdef WRR_ARB_WATCHDOG_EN
            else if (bus.ack_i) begin
               wd_d = '0;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               do_release = 1'b1;
               timeout_d  = 1'b1;
               wd_d       = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      if (do_release) begin
         state_d  = IDLE;
         grant_d  = '0;
         ptr_d    = next_ptr;
         owner_d  = '0;
         credit_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         credit_q  <= '0;
         grant_q   <= '0;
`ifdef WRR_ARB_WATCHDOG_EN
         wd_q      <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         credit_q  <= credit_d;
         grant_q   <= grant_d;
`ifdef WRR_ARB_WATCHDOG_EN
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.grant_o     = grant_q;
   assign bus.grant_idx_o = owner_q;
   assign bus.busy_o      = (state_q == LOCKED);
`ifdef WRR_ARB_WATCHDOG_EN
   assign bus.timeout_o   = timeout_q;
`else
   assign bus.timeout_o   = 1'b0;
`endif
   assign dbg_state_o     = state_q;
endmodule
